// File: rtl/hist_pkg.sv
// Shared types and helpers for the histogram acquisition controller.
package hist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACQ,
        DRAIN,
        READ
    } state_t;

    localparam int unsigned DRAIN_CYC = 2;

    // Saturating increment of the low `width` bits of val (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] cap;
        cap = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= cap) ? cap : val + 32'd1;
    endfunction

endpackage

// File: rtl/hist_rmw_pipe.sv
// Two-stage saturating read-modify-write increment pipe for the histogram BRAM.
module hist_rmw_pipe
    import hist_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              strobe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [CNT_W-1:0]  rdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [CNT_W-1:0]  wdata
);

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic              w2_valid;
    logic [ADDR_W-1:0] w2_addr;
    logic [CNT_W-1:0]  w2_data;
    logic [CNT_W-1:0]  base;
    logic [CNT_W-1:0]  next_val;

    // rdata misses both the write still on the port and the one committed at the
    // edge that sampled the read (read-first), so either may need forwarding.
    always_comb begin
        base = rdata;
        if (we && waddr == s1_addr) begin
            base = wdata;
        end else if (w2_valid && w2_addr == s1_addr) begin
            base = w2_data;
        end
        next_val = CNT_W'(sat_inc(32'(base), CNT_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            w2_valid <= 1'b0;
            w2_addr  <= '0;
            w2_data  <= '0;
        end else begin
            s1_valid <= en && strobe;
            s1_addr  <= addr;
            we       <= s1_valid;
            if (s1_valid) begin
                waddr <= s1_addr;
                wdata <= next_val;
            end
            w2_valid <= we;
            w2_addr  <= waddr;
            w2_data  <= wdata;
        end
    end

endmodule

// File: rtl/hist_acq_ctrl.sv
// Acquisition sequencer: clear histogram, count strobes over a dwell window, stream bins out.
module hist_acq_ctrl
    import hist_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ADDR_W-1:0]  Addr,
    input  logic               Memory_add,
    output logic [ADDR_W-1:0]  mem_raddr,
    input  logic [CNT_W-1:0]   mem_rdata,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [CNT_W-1:0]   mem_wdata,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_last,
    output logic               busy,
    output logic               done,
    output logic [31:0]        event_cnt
);

    localparam logic [ADDR_W-1:0] LAST_BIN = '1;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  clr_addr;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [1:0]         drain_cnt;
    logic               drain_last;
    logic [ADDR_W-1:0]  rptr;
    logic               rd_issued_all;
    logic               rd_inflight;
    logic [ADDR_W-1:0]  rd_inflight_addr;
    logic               rd_issue;
    logic               acq_en;
    logic               pipe_we;
    logic [ADDR_W-1:0]  pipe_waddr;
    logic [CNT_W-1:0]   pipe_wdata;

    hist_rmw_pipe #(
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) u_rmw (
        .clk   (clk),
        .rst   (rst),
        .en    (acq_en),
        .strobe(Memory_add),
        .addr  (Addr),
        .rdata (mem_rdata),
        .we    (pipe_we),
        .waddr (pipe_waddr),
        .wdata (pipe_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        drain_last = (drain_cnt == 2'(DRAIN_CYC - 1));
        state_nxt  = state;
        busy       = (state != IDLE);
        done       = (state == DRAIN) && drain_last;
        acq_en     = (state == ACQ);
        rd_last    = rd_valid && (rd_addr == LAST_BIN);
        // One read in flight at a time; it is launched only if its data will have a free slot.
        rd_issue   = (state == READ) && !rd_issued_all && !rd_inflight && (!rd_valid || rd_ready);
        mem_raddr  = '0;
        mem_we     = pipe_we;
        mem_waddr  = pipe_waddr;
        mem_wdata  = pipe_wdata;

        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = '0;
                if (clr_addr == LAST_BIN) state_nxt = (dwell_cnt == '0) ? DRAIN : ACQ;
            end
            ACQ: begin
                mem_raddr = Addr;
                if (dwell_cnt == DWELL_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_last) state_nxt = READ;
            end
            READ: begin
                mem_raddr = rptr;
                if (rd_valid && rd_ready && rd_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr         <= '0;
            dwell_cnt        <= '0;
            drain_cnt        <= '0;
            event_cnt        <= '0;
            rptr             <= '0;
            rd_issued_all    <= 1'b0;
            rd_inflight      <= 1'b0;
            rd_inflight_addr <= '0;
            rd_valid         <= 1'b0;
            rd_addr          <= '0;
            rd_data          <= '0;
        end else begin
            if (state == IDLE && start) begin
                dwell_cnt     <= dwell;
                event_cnt     <= '0;
                clr_addr      <= '0;
                rptr          <= '0;
                rd_issued_all <= 1'b0;
            end
            if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
            if (state == ACQ) begin
                dwell_cnt <= dwell_cnt - 1'b1;
                if (Memory_add) event_cnt <= sat_inc(event_cnt, 32);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            rd_inflight <= rd_issue;
            if (rd_issue) begin
                rd_inflight_addr <= rptr;
                rptr             <= rptr + 1'b1;
                if (rptr == LAST_BIN) rd_issued_all <= 1'b1;
            end
            if (rd_inflight) begin
                rd_valid <= 1'b1;
                rd_addr  <= rd_inflight_addr;
                rd_data  <= mem_rdata;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hist_acq_ctrl.sv
// Randomized bench for hist_acq_ctrl against a cycle-indexed behavioural model with a BRAM model.
module tb_hist_acq_ctrl;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DWELL_W = 24;
    localparam int unsigned NBINS   = 1 << ADDR_W;
    localparam int unsigned CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [ADDR_W-1:0]  Addr = '0;
    logic               Memory_add = 1'b0;
    logic [ADDR_W-1:0]  mem_raddr;
    logic [CNT_W-1:0]   mem_rdata = '0;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [CNT_W-1:0]   mem_wdata;
    logic               rd_valid;
    logic               rd_ready = 1'b0;
    logic [ADDR_W-1:0]  rd_addr;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_last;
    logic               busy;
    logic               done;
    logic [31:0]        event_cnt;

    hist_acq_ctrl #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .DWELL_W(DWELL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dwell     (dwell),
        .Addr      (Addr),
        .Memory_add(Memory_add),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .done      (done),
        .event_cnt (event_cnt)
    );

    always #5 clk = ~clk;

    // Simple-dual-port BRAM, 1-cycle read latency, read-first.
    logic [CNT_W-1:0] bram [NBINS];
    always @(posedge clk) begin
        if (mem_we) bram[mem_waddr] <= mem_wdata;
        mem_rdata <= bram[mem_raddr];
    end

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an acquisition is a timeline indexed by cycles since the accepted start.
    bit          m_active = 1'b0;
    int          m_n = 0;
    int          m_dw = 0;
    int unsigned m_ev = 0;
    int          m_ridx = 0;
    int          m_ngot = 0;
    int unsigned exp_bin [NBINS];
    int unsigned got [NBINS];
    bit          p0_v = 0, p1_v = 0, p2_v = 0;
    int          p0_a = 0, p1_a = 0, p2_a = 0;
    int          p0_d = 0, p1_d = 0, p2_d = 0;
    bit          prev_stall = 0;
    int          rphase;

    always @(negedge clk) begin
        p2_v = p1_v; p2_a = p1_a; p2_d = p1_d;
        p1_v = p0_v; p1_a = p0_a; p1_d = p0_d;
        p0_v = 0;
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_rd_last", rd_last, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_raddr", mem_raddr, 0);
            chk("rst_mem_waddr", mem_waddr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_rd_addr", rd_addr, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_event_cnt", event_cnt, 0);
            m_active = 0; m_ev = 0; prev_stall = 0;
            p1_v = 0; p2_v = 0;
        end else begin
            rphase = NBINS + m_dw + 2;
            chk("busy", busy, m_active);
            chk("done", done, m_active && (m_n == NBINS + m_dw + 1));
            chk("event_cnt", event_cnt, m_ev);
            if (m_active && m_n < NBINS) begin
                chk("clear_we", mem_we, 1);
                chk("clear_waddr", mem_waddr, m_n);
                chk("clear_wdata", mem_wdata, 0);
            end else begin
                chk("inc_we", mem_we, p2_v);
                if (p2_v) begin
                    chk("inc_waddr", mem_waddr, p2_a);
                    chk("inc_wdata", mem_wdata, p2_d);
                end
            end
            if (m_active && m_n >= rphase) begin
                if (m_n == rphase + 2 && m_ridx == 0) chk("first_valid", rd_valid, 1);
                if (prev_stall) chk("stall_hold", rd_valid, 1);
                if (rd_valid) begin
                    chk("rd_addr", rd_addr, m_ridx);
                    chk("rd_data", rd_data, exp_bin[m_ridx]);
                    chk("rd_last", rd_last, m_ridx == NBINS - 1);
                end
            end else begin
                chk("rd_valid_quiet", rd_valid, 0);
            end
            prev_stall = rd_valid && !rd_ready;

            if (m_active) begin
                if (m_n >= NBINS && m_n < NBINS + m_dw && Memory_add) begin
                    if (exp_bin[Addr] < CMAX) exp_bin[Addr] = exp_bin[Addr] + 1;
                    if (m_ev != 32'hFFFF_FFFF) m_ev = m_ev + 1;
                    p0_v = 1; p0_a = Addr; p0_d = exp_bin[Addr];
                end
                if (m_n >= rphase && rd_valid && rd_ready) begin
                    got[m_ridx] = rd_data;
                    m_ngot++;
                    if (m_ridx == NBINS - 1) m_active = 0;
                    m_ridx++;
                end
                m_n++;
            end else if (start) begin
                m_active = 1; m_n = 0; m_dw = dwell; m_ev = 0; m_ridx = 0; m_ngot = 0;
                foreach (exp_bin[i]) exp_bin[i] = 0;
                foreach (got[i]) got[i] = 0;
            end
        end
    end

    int sched [int];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned got_sum();
        int unsigned s = 0;
        foreach (got[i]) s += got[i];
        return s;
    endfunction

    // Strobe schedule keys are offsets from the start of the dwell window (1 = first ACQ cycle).
    task automatic acquire(input int dw, input bit rnd_ready, input bit start_noise,
                           input int rst_at, output int edges);
        int j;
        start = 1'b1;
        dwell = DWELL_W'(dw);
        tick();
        start = 1'b0;
        edges = 1;
        for (int e = 1; e <= int'(NBINS) + dw + 2; e++) begin
            j = e - int'(NBINS);
            if (sched.exists(j)) begin
                Memory_add = 1'b1;
                Addr = ADDR_W'(sched[j]);
            end else begin
                Memory_add = 1'b0;
                Addr = ADDR_W'($urandom);
            end
            if (rst_at >= 0 && j == rst_at) begin
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
                Memory_add = 1'b0;
                return;
            end
            tick();
            edges++;
        end
        Memory_add = 1'b0;
        for (int k = 0; k < 3000 && busy; k++) begin
            rd_ready   = rnd_ready ? 1'($urandom % 2) : 1'b1;
            start      = start_noise ? ($urandom % 4 == 0) : 1'b0;
            Memory_add = 1'($urandom % 2);
            Addr       = ADDR_W'($urandom);
            tick();
            edges++;
        end
        start = 1'b0;
        Memory_add = 1'b0;
        rd_ready = 1'b0;
        chk("acq_finished", busy, 0);
    endtask

    int ed;

    initial begin
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // Basic: bins 3,3,7 in separated cycles.
        sched.delete();
        sched[2] = 3; sched[6] = 3; sched[10] = 7;
        acquire(20, 0, 0, -1, ed);
        chk("basic_bin3", got[3], 2);
        chk("basic_bin7", got[7], 1);
        chk("basic_bin0", got[0], 0);
        chk("basic_sum", got_sum(), 3);
        chk("basic_evt", event_cnt, 3);
        chk("basic_ngot", m_ngot, 256);
        chk("basic_rate", ed <= int'(NBINS) + 20 + 3 + 2 * int'(NBINS) + 2, 1);

        // Back-to-back strobes exercise both forwarding paths.
        sched.delete();
        for (int i = 1; i <= 5; i++) sched[i] = 10;
        sched[6] = 10; sched[7] = 11; sched[8] = 10;
        acquire(20, 0, 0, -1, ed);
        chk("fwd_bin10", got[10], 7);
        chk("fwd_bin11", got[11], 1);
        chk("fwd_evt", event_cnt, 8);

        // Saturation at 15 while event_cnt keeps counting.
        sched.delete();
        for (int i = 1; i <= 20; i++) sched[i] = 0;
        acquire(30, 0, 0, -1, ed);
        chk("sat_bin0", got[0], 15);
        chk("sat_evt", event_cnt, 20);

        // Zero dwell: strobes around the skipped window are all dropped.
        sched.delete();
        sched[0] = 1; sched[1] = 2; sched[2] = 3;
        acquire(0, 0, 0, -1, ed);
        chk("dw0_sum", got_sum(), 0);
        chk("dw0_evt", event_cnt, 0);

        // Last ACQ cycle counts, first DRAIN cycle does not.
        sched.delete();
        sched[4] = 9; sched[5] = 9;
        acquire(4, 0, 0, -1, ed);
        chk("edge_bin9", got[9], 1);
        chk("edge_evt", event_cnt, 1);

        // Backpressure with start noise during readout.
        sched.delete();
        sched[1] = 200; sched[3] = 255;
        acquire(10, 1, 1, -1, ed);
        chk("bp_ngot", m_ngot, 256);
        chk("bp_bin255", got[255], 1);
        chk("bp_bin200", got[200], 1);
        tick();
        chk("bp_start_ignored", busy, 0);

        // Random acquisitions concentrated on a few bins.
        for (int r = 0; r < 6; r++) begin
            int dw;
            dw = $urandom_range(0, 40);
            sched.delete();
            for (int j = -2; j <= dw + 2; j++) begin
                if ($urandom % 3 != 0) sched[j] = $urandom_range(0, 7);
            end
            acquire(dw, r % 2 == 1, 1, -1, ed);
            chk("rand_ngot", m_ngot, 256);
        end

        // Reset mid-ACQ, then a fresh acquisition with a single strobe.
        sched.delete();
        for (int i = 1; i <= 15; i++) sched[i] = 5;
        acquire(30, 0, 0, 10, ed);
        chk("rst_mid_idle", busy, 0);
        tick();
        sched.delete();
        sched[3] = 5;
        acquire(8, 1, 0, -1, ed);
        chk("rst2_bin5", got[5], 1);
        chk("rst2_sum", got_sum(), 1);
        chk("rst2_ngot", m_ngot, 256);
        chk("rst2_evt", event_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
